avalon_gpio_bank: RTL and testbench

//  Parametrised Avalon-MM GPIO peripheral replacing the fixed key/switch/LED PIOs in the Qsys system.
//  One bank of IN_WIDTH inputs (keys+switches): synchronised, debounced, per-bit rising/falling edge capture, masked IRQ.
//  One bank of OUT_WIDTH outputs (LEDs) with atomic set/clear. Slave on the system interconnect, fixed read latency 1.

---
 rtl/gpio_bank_pkg.sv | 16 +
 rtl/avalon_gpio_bank_if.sv | 19 +
 rtl/gpio_debounce.sv | 57 +++++
 rtl/avalon_gpio_bank.sv | 136 +++++++++++++
 tb/tb_avalon_gpio_bank.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/gpio_bank_pkg.sv
// Package gpio_bank_pkg: register word addresses and bus widths shared by
// the GPIO bank interface, top level and testbench.
package gpio_bank_pkg;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;

    localparam logic [ADDR_W-1:0] ADDR_DATA_IN  = 4'd0;
    localparam logic [ADDR_W-1:0] ADDR_DATA_OUT = 4'd1;
    localparam logic [ADDR_W-1:0] ADDR_OUT_SET  = 4'd2;
    localparam logic [ADDR_W-1:0] ADDR_OUT_CLR  = 4'd3;
    localparam logic [ADDR_W-1:0] ADDR_IRQ_MASK = 4'd4;
    localparam logic [ADDR_W-1:0] ADDR_EDGE_CAP = 4'd5;
    localparam logic [ADDR_W-1:0] ADDR_RISE_EN  = 4'd6;
    localparam logic [ADDR_W-1:0] ADDR_FALL_EN  = 4'd7;
    localparam logic [ADDR_W-1:0] ADDR_TSTAMP   = 4'd8;
endpackage

// File: rtl/avalon_gpio_bank_if.sv
// Interface avalon_gpio_bank_if: Avalon-MM slave bus of the GPIO bank.
//  address   4   word address
//  read      1   read strobe
//  write     1   write strobe
//  writedata 32  write data
//  readdata  32  read data, valid the cycle after read
// Modports: master (interconnect side), slave (peripheral side).
interface avalon_gpio_bank_if;
    import gpio_bank_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;

    modport master (output address, output read, output write, output writedata, input readdata);
    modport slave  (input address, input read, input write, input writedata, output readdata);
endinterface

// File: rtl/gpio_debounce.sv
// Module gpio_debounce: one input bit, synchroniser chain followed by a
// stability counter.
//  clk    in  system clock
//  reset  in  synchronous active-high reset
//  i_din  in  asynchronous input bit
//  o_deb  out debounced bit
// The debounced bit toggles once the synchronised bit has differed from it
// for DEBOUNCE_CYCLES consecutive cycles; DEBOUNCE_CYCLES=0 bypasses the counter.
module gpio_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_din,
    output logic o_deb
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_synced;

    always_ff @(posedge clk) begin
        if (reset) r_sync <= '0;
        else       r_sync <= {r_sync[SYNC_STAGES-2:0], i_din};
    end

    assign w_synced = r_sync[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign o_deb = w_synced;
        end else begin : g_count
            localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

            logic [CNT_W-1:0] r_cnt;
            logic             r_deb;

            // Counter only runs while the input disagrees with the held value;
            // any agreement restarts the stability window.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_cnt <= '0;
                    r_deb <= 1'b0;
                end else if (w_synced == r_deb) begin
                    r_cnt <= '0;
                end else if (r_cnt == CNT_LAST) begin
                    r_deb <= ~r_deb;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign o_deb = r_deb;
        end
    endgenerate
endmodule

// File: rtl/avalon_gpio_bank.sv
// Module avalon_gpio_bank: Avalon-MM GPIO peripheral, fixed read latency 1.
//  clk       in   system clock
//  reset     in   synchronous active-high reset
//  bus       slave modport of avalon_gpio_bank_if (address/read/write/writedata/readdata)
//  irq       out  registered level interrupt, |(EDGE_CAP & IRQ_MASK)
//  gpio_in   in   IN_WIDTH asynchronous inputs
//  gpio_out  out  OUT_WIDTH outputs from the DATA_OUT register
// Optional feature macro: GPIO_TIMESTAMP_EN adds a free-running cycle counter
// and the TSTAMP register (address 8); without it address 8 reads 0.
module avalon_gpio_bank
    import gpio_bank_pkg::*;
#(
    parameter int                   IN_WIDTH        = 14,
    parameter int                   OUT_WIDTH       = 10,
    parameter int                   SYNC_STAGES     = 2,
    parameter int                   DEBOUNCE_CYCLES = 50000,
    parameter logic [OUT_WIDTH-1:0] OUT_RESET       = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    avalon_gpio_bank_if.slave    bus,
    output logic                 irq,
    input  logic [IN_WIDTH-1:0]  gpio_in,
    output logic [OUT_WIDTH-1:0] gpio_out
);
    logic [IN_WIDTH-1:0]  w_deb;
    logic [IN_WIDTH-1:0]  r_deb_prev;
    logic [OUT_WIDTH-1:0] r_out;
    logic [IN_WIDTH-1:0]  r_irq_mask;
    logic [IN_WIDTH-1:0]  r_edge_cap;
    logic [IN_WIDTH-1:0]  r_rise_en;
    logic [IN_WIDTH-1:0]  r_fall_en;
    logic                 r_irq;
    logic [DATA_W-1:0]    r_readdata;
    logic [DATA_W-1:0]    w_rd_mux;
    logic [DATA_W-1:0]    w_tstamp;
    logic [IN_WIDTH-1:0]  w_cap_set;
    logic [IN_WIDTH-1:0]  w_cap_clr;
    logic [IN_WIDTH-1:0]  w_cap_next;
    logic                 w_unused;

    genvar gi;
    generate
        for (gi = 0; gi < IN_WIDTH; gi++) begin : g_in
            gpio_debounce #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_deb (
                .clk   (clk),
                .reset (reset),
                .i_din (gpio_in[gi]),
                .o_deb (w_deb[gi])
            );
        end
    endgenerate

    // Upper writedata bits beyond the channel widths are don't-care.
    assign w_unused = ^bus.writedata;

    always_comb begin
        w_cap_clr  = (bus.write && bus.address == ADDR_EDGE_CAP) ? bus.writedata[IN_WIDTH-1:0] : '0;
        w_cap_set  = (w_deb & ~r_deb_prev & r_rise_en) | (~w_deb & r_deb_prev & r_fall_en);
        // New edges are OR-ed in after the clear so a coincident event survives.
        w_cap_next = (r_edge_cap & ~w_cap_clr) | w_cap_set;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_deb_prev <= '0;
            r_out      <= OUT_RESET;
            r_irq_mask <= '0;
            r_edge_cap <= '0;
            r_rise_en  <= '0;
            r_fall_en  <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_deb_prev <= w_deb;
            r_edge_cap <= w_cap_next;
            r_irq      <= |(r_edge_cap & r_irq_mask);
            if (bus.write) begin
                unique case (bus.address)
                    ADDR_DATA_OUT: r_out      <= bus.writedata[OUT_WIDTH-1:0];
                    ADDR_OUT_SET:  r_out      <= r_out | bus.writedata[OUT_WIDTH-1:0];
                    ADDR_OUT_CLR:  r_out      <= r_out & ~bus.writedata[OUT_WIDTH-1:0];
                    ADDR_IRQ_MASK: r_irq_mask <= bus.writedata[IN_WIDTH-1:0];
                    ADDR_RISE_EN:  r_rise_en  <= bus.writedata[IN_WIDTH-1:0];
                    ADDR_FALL_EN:  r_fall_en  <= bus.writedata[IN_WIDTH-1:0];
                    default: ;
                endcase
            end
        end
    end

`ifdef GPIO_TIMESTAMP_EN
    logic [DATA_W-1:0] r_cycle;
    logic [DATA_W-1:0] r_tstamp;

    // Only the first event after EDGE_CAP was fully cleared is stamped.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle  <= '0;
            r_tstamp <= '0;
        end else begin
            r_cycle <= r_cycle + 1'b1;
            if (r_edge_cap == '0 && w_cap_next != '0) r_tstamp <= r_cycle;
        end
    end

    assign w_tstamp = r_tstamp;
`else
    assign w_tstamp = '0;
`endif

    always_comb begin
        w_rd_mux = '0;
        unique case (bus.address)
            ADDR_DATA_IN:  w_rd_mux[IN_WIDTH-1:0]  = w_deb;
            ADDR_DATA_OUT: w_rd_mux[OUT_WIDTH-1:0] = r_out;
            ADDR_IRQ_MASK: w_rd_mux[IN_WIDTH-1:0]  = r_irq_mask;
            ADDR_EDGE_CAP: w_rd_mux[IN_WIDTH-1:0]  = r_edge_cap;
            ADDR_RISE_EN:  w_rd_mux[IN_WIDTH-1:0]  = r_rise_en;
            ADDR_FALL_EN:  w_rd_mux[IN_WIDTH-1:0]  = r_fall_en;
            ADDR_TSTAMP:   w_rd_mux                = w_tstamp;
            default:       w_rd_mux                = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)         r_readdata <= '0;
        else if (bus.read) r_readdata <= w_rd_mux;
    end

    assign bus.readdata = r_readdata;
    assign irq          = r_irq;
    assign gpio_out     = r_out;
endmodule

// File: tb/tb_avalon_gpio_bank.sv
module tb_avalon_gpio_bank;
    localparam int IN_W = 14;
    localparam int OUT_W = 10;
    localparam int SYNC = 2;
    localparam int DB = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic irq;
    logic [IN_W-1:0] gpio_in = '0;
    logic [OUT_W-1:0] gpio_out;

    avalon_gpio_bank_if bus();

    avalon_gpio_bank #(
        .IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .SYNC_STAGES(SYNC),
        .DEBOUNCE_CYCLES(DB), .OUT_RESET('0)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus.slave), .irq(irq),
        .gpio_in(gpio_in), .gpio_out(gpio_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Behavioural model: input history queue, run-length debounce, register map.
    logic [IN_W-1:0] m_hist[$];
    logic [IN_W-1:0] m_deb, m_deb_prev, m_mask, m_cap, m_rise, m_fall;
    logic [OUT_W-1:0] m_out;
    logic m_irq;
    logic [31:0] m_rd, m_cyc, m_ts;
    int m_run[IN_W];

    always @(posedge clk) begin
        logic [IN_W-1:0] old_sync, new_deb, set_v, clr_v, cap_new;
        if (reset) begin
            m_hist.delete();
            for (int k = 0; k < SYNC; k++) m_hist.push_back('0);
            for (int k = 0; k < IN_W; k++) m_run[k] = 0;
            m_deb = '0; m_deb_prev = '0; m_mask = '0; m_cap = '0;
            m_rise = '0; m_fall = '0; m_out = '0; m_irq = 1'b0;
            m_rd = '0; m_cyc = '0; m_ts = '0;
            chk_en = 1'b1;
        end else begin
            old_sync = m_hist[SYNC-1];
            new_deb = m_deb;
            for (int k = 0; k < IN_W; k++) begin
                if (old_sync[k] != m_deb[k]) begin
                    m_run[k]++;
                    if (m_run[k] == DB) begin
                        new_deb[k] = ~m_deb[k];
                        m_run[k] = 0;
                    end
                end else m_run[k] = 0;
            end
            m_hist.push_front(gpio_in);
            void'(m_hist.pop_back());
            if (bus.read) begin
                case (bus.address)
                    4'd0: m_rd = 32'(m_deb);
                    4'd1: m_rd = 32'(m_out);
                    4'd4: m_rd = 32'(m_mask);
                    4'd5: m_rd = 32'(m_cap);
                    4'd6: m_rd = 32'(m_rise);
                    4'd7: m_rd = 32'(m_fall);
`ifdef GPIO_TIMESTAMP_EN
                    4'd8: m_rd = m_ts;
`endif
                    default: m_rd = '0;
                endcase
            end
            m_irq = |(m_cap & m_mask);
            clr_v = (bus.write && bus.address == 4'd5) ? bus.writedata[IN_W-1:0] : '0;
            set_v = (m_deb & ~m_deb_prev & m_rise) | (~m_deb & m_deb_prev & m_fall);
            cap_new = (m_cap & ~clr_v) | set_v;
            if (m_cap == '0 && cap_new != '0) m_ts = m_cyc;
            m_cyc = m_cyc + 1;
            m_cap = cap_new;
            if (bus.write) begin
                case (bus.address)
                    4'd1: m_out = bus.writedata[OUT_W-1:0];
                    4'd2: m_out = m_out | bus.writedata[OUT_W-1:0];
                    4'd3: m_out = m_out & ~bus.writedata[OUT_W-1:0];
                    4'd4: m_mask = bus.writedata[IN_W-1:0];
                    4'd6: m_rise = bus.writedata[IN_W-1:0];
                    4'd7: m_fall = bus.writedata[IN_W-1:0];
                    default: ;
                endcase
            end
            m_deb_prev = m_deb;
            m_deb = new_deb;
        end
    end

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            n_checks++;
            if (gpio_out !== m_out || irq !== m_irq || bus.readdata !== m_rd) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t gpio_out=%h/%h irq=%b/%b readdata=%h/%h (actual/required)",
                         $time, gpio_out, m_out, irq, m_irq, bus.readdata, m_rd);
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end else $display("ok   %s = %h", nm, act);
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] d);
        bus.address = a; bus.writedata = d; bus.write = 1'b1;
        @(negedge clk);
        bus.write = 1'b0;
        $display("wr   addr=%0d data=%h", a, d);
    endtask

    task automatic do_read(input logic [3:0] a, input logic [31:0] exp, input string nm);
        bus.address = a; bus.read = 1'b1;
        @(negedge clk);
        bus.read = 1'b0;
        check(nm, bus.readdata, exp);
    endtask

    logic [31:0] c0;

    initial begin
        bus.address = '0; bus.read = 1'b0; bus.write = 1'b0; bus.writedata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_gpio_out", 32'(gpio_out), 32'h0);
        check("reset_irq", 32'(irq), 32'h0);
        for (int a = 0; a <= 8; a++) do_read(4'(a), 32'h0, $sformatf("reset_read_%0d", a));

        // Debounce latency: held input reaches DATA_IN 6 cycles later.
        gpio_in[3] = 1'b1; bus.address = 4'd0; bus.read = 1'b1;
        for (int j = 1; j <= 7; j++) begin
            @(negedge clk);
            if (j == 6) check("deb_edge5", bus.readdata, 32'h0);
            if (j == 7) check("deb_edge6", bus.readdata, 32'h8);
        end
        bus.read = 1'b0;
        gpio_in[3] = 1'b0;
        repeat (10) @(negedge clk);
        gpio_in[3] = 1'b1;
        repeat (3) @(negedge clk);
        gpio_in[3] = 1'b0;
        repeat (10) @(negedge clk);
        do_read(4'd0, 32'h0, "glitch_ignored");

        // Output register and atomic set/clear.
        do_write(4'd1, 32'h0F0);
        do_write(4'd2, 32'h003);
        do_write(4'd3, 32'h010);
        check("gpio_out_setclr", 32'(gpio_out), 32'h0E3);
        do_read(4'd1, 32'h0E3, "data_out_read");
        do_read(4'd2, 32'h0, "out_set_reads0");
        do_write(4'd1, 32'hFFFFF);
        check("gpio_out_trunc", 32'(gpio_out), 32'h3FF);

        // Rising-edge capture and irq.
        do_write(4'd6, 32'h1);
        do_write(4'd4, 32'h1);
        gpio_in[0] = 1'b1;
        repeat (10) @(negedge clk);
        do_read(4'd5, 32'h1, "rise_cap");
        check("rise_irq", 32'(irq), 32'h1);
        do_write(4'd5, 32'h1);
        check("irq_after_w1c_edge", 32'(irq), 32'h1);
        @(negedge clk);
        check("irq_cleared", 32'(irq), 32'h0);
        gpio_in[0] = 1'b0;
        repeat (12) @(negedge clk);
        gpio_in[0] = 1'b1;
        repeat (6) @(negedge clk);
        do_write(4'd5, 32'h1);
        do_read(4'd5, 32'h1, "set_beats_w1c");

        // Falling-edge capture with irq masked, then unmasked.
        do_write(4'd5, 32'h3FFF);
        do_write(4'd4, 32'h0);
        do_write(4'd7, 32'h2);
        gpio_in[1] = 1'b1;
        repeat (12) @(negedge clk);
        gpio_in[1] = 1'b0;
        repeat (12) @(negedge clk);
        do_read(4'd5, 32'h2, "fall_cap");
        check("fall_irq_masked", 32'(irq), 32'h0);
        do_write(4'd4, 32'h2);
        @(negedge clk);
        check("fall_irq_unmasked", 32'(irq), 32'h1);

`ifdef GPIO_TIMESTAMP_EN
        do_write(4'd7, 32'h0);
        do_write(4'd6, 32'h30);
        do_write(4'd5, 32'h3FFF);
        repeat (3) @(negedge clk);
        c0 = m_cyc;
        gpio_in[4] = 1'b1;
        repeat (100) @(negedge clk);
        gpio_in[5] = 1'b1;
        repeat (12) @(negedge clk);
        do_read(4'd8, c0 + 32'd6, "tstamp_first");
        do_write(4'd5, 32'h3FFF);
        gpio_in[4] = 1'b0;
        repeat (12) @(negedge clk);
        c0 = m_cyc;
        gpio_in[4] = 1'b1;
        repeat (12) @(negedge clk);
        do_read(4'd8, c0 + 32'd6, "tstamp_updated");
`else
        gpio_in[4] = 1'b1;
        repeat (12) @(negedge clk);
        do_read(4'd8, 32'h0, "tstamp_absent");
`endif

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
